// File: rtl/pixel_scan_reader_if.sv
// rtl/pixel_scan_reader_if.sv - control, frame-RAM and pixel-stream signals of the scan reader
interface pixel_scan_reader_if #(
   parameter int ADDR_W = 14
);
   logic              start;
   logic [1:0]        mode;
   logic              stall;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic [7:0]        pix_out;
   logic              pix_valid;
   logic              line_start;
   logic              busy;
   logic              done;

   modport master (
      input  start, mode, stall, mem_rdata,
      output mem_rd_en, mem_addr, pix_out, pix_valid, line_start, busy, done
   );

   modport slave (
      output start, mode, stall, mem_rdata,
      input  mem_rd_en, mem_addr, pix_out, pix_valid, line_start, busy, done
   );
endinterface

// File: rtl/pixel_scan_reader.sv
// rtl/pixel_scan_reader.sv - streams a frame from RAM in one of four scan orders
// Optional LINE_GAP_EN inserts one bubble cycle between scan lines.
module pixel_scan_reader #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int ADDR_W = 14
) (
   input  logic                clk,
   input  logic                reset,
   pixel_scan_reader_if.master bus
);
   localparam int MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;
   localparam int CW      = $clog2(MAX_DIM + 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

   state_t            state_q;
   logic [1:0]        mode_q;
   logic [CW-1:0]     i_q;
   logic [CW-1:0]     o_q;
   logic              rd_en_q;
   logic              rd_first_q;
   logic [ADDR_W-1:0] addr_q;
   logic              s1_valid_q;
   logic              s1_first_q;
   logic [7:0]        pix_q;
   logic              pix_valid_q;
   logic              line_start_q;
   logic              busy_q;
   logic              done_q;
   logic              last_i;
   logic              last_o;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] m,
                                                 input logic [CW-1:0] i,
                                                 input logic [CW-1:0] o);
      logic [ADDR_W-1:0] x;
      logic [ADDR_W-1:0] y;
      case (m)
         2'd0: begin x = ADDR_W'(i); y = ADDR_W'(o); end
         2'd1: begin x = ADDR_W'(IMG_W - 1) - ADDR_W'(i); y = ADDR_W'(o); end
         2'd2: begin x = ADDR_W'(o); y = ADDR_W'(i); end
         default: begin x = ADDR_W'(o); y = ADDR_W'(IMG_H - 1) - ADDR_W'(i); end
      endcase
      return y * ADDR_W'(IMG_W) + x;
   endfunction

   // Column scans swap the roles of the inner and outer counters.
   assign last_i = (i_q == CW'(mode_q[1] ? IMG_H - 1 : IMG_W - 1));
   assign last_o = (o_q == CW'(mode_q[1] ? IMG_W - 1 : IMG_H - 1));

   assign bus.mem_rd_en  = rd_en_q & ~bus.stall;
   assign bus.mem_addr   = addr_q;
   assign bus.pix_out    = pix_q;
   assign bus.pix_valid  = pix_valid_q;
   assign bus.line_start = line_start_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         mode_q       <= 2'd0;
         i_q          <= '0;
         o_q          <= '0;
         rd_en_q      <= 1'b0;
         rd_first_q   <= 1'b0;
         addr_q       <= '0;
         s1_valid_q   <= 1'b0;
         s1_first_q   <= 1'b0;
         pix_q        <= 8'd0;
         pix_valid_q  <= 1'b0;
         line_start_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         // A stalled edge freezes the whole pipeline; the RAM holds its data meanwhile.
         if (!bus.stall) begin
            s1_valid_q   <= rd_en_q;
            s1_first_q   <= rd_first_q;
            pix_valid_q  <= s1_valid_q;
            line_start_q <= s1_valid_q & s1_first_q;
            if (s1_valid_q) begin
               pix_q <= bus.mem_rdata;
            end
         end

         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q    <= S_READ;
                  busy_q     <= 1'b1;
                  mode_q     <= bus.mode;
                  i_q        <= '0;
                  o_q        <= '0;
                  rd_en_q    <= 1'b1;
                  rd_first_q <= 1'b1;
                  addr_q     <= addr_of(bus.mode, '0, '0);
               end
            end
            S_READ: begin
               if (!bus.stall) begin
                  if (!rd_en_q) begin
                     rd_en_q <= 1'b1;
                  end else if (last_i && last_o) begin
                     rd_en_q <= 1'b0;
                     state_q <= S_DRAIN;
                  end else if (last_i) begin
                     i_q        <= '0;
                     o_q        <= o_q + CW'(1);
                     rd_first_q <= 1'b1;
                     addr_q     <= addr_of(mode_q, '0, o_q + CW'(1));
`ifdef LINE_GAP_EN
                     rd_en_q    <= 1'b0;
`else
                     rd_en_q    <= 1'b1;
`endif
                  end else begin
                     i_q        <= i_q + CW'(1);
                     rd_first_q <= 1'b0;
                     addr_q     <= addr_of(mode_q, i_q + CW'(1), o_q);
                  end
               end
            end
            S_DRAIN: begin
               // Final pixel is on the outputs and nothing follows it in stage 1.
               if (!bus.stall && pix_valid_q && !s1_valid_q) begin
                  state_q <= S_FIN;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pixel_scan_reader.sv
// tb/tb_pixel_scan_reader.sv - directed and randomized checks of pixel_scan_reader against a scan-order model
module tb_pixel_scan_reader;
   localparam int W    = 4;
   localparam int H    = 3;
   localparam int AW   = 4;
   localparam int NPIX = W * H;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] mem [0:15];
   logic [7:0] rdata_q = 8'd0;
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   pixel_scan_reader_if #(.ADDR_W(AW)) bus ();

   pixel_scan_reader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always @(posedge clk) if (bus.mem_rd_en) rdata_q <= mem[bus.mem_addr];
   assign bus.mem_rdata = rdata_q;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_en"}, bus.mem_rd_en, 0);
      check({tag, "_addr"}, bus.mem_addr, 0);
      check({tag, "_pix"}, bus.pix_out, 0);
      check({tag, "_valid"}, bus.pix_valid, 0);
      check({tag, "_ls"}, bus.line_start, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
   endtask

   // stall_kind: 0 none, 1 two cycles starting when pixel value 5 shows, 2 random
   task automatic run_frame(input logic [1:0] m, input int stall_kind, input bit rnd,
                            input bit prestarted, input bit start_at_done);
      int   qa[$];
      bit   qf[$];
      int   gaps, cyc, idx, nstall, first_v, last_acc, bubbles, held5, stall_cnt;
      bit   seen_done, p_stall, stalled_once;
      logic [7:0] p_out;
      logic p_v, p_ls;

      for (int a = 0; a < 16; a++) mem[a] = rnd ? 8'($urandom) : 8'(a);
      case (m)
         2'd0: for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) begin qa.push_back(y*W + x); qf.push_back(x == 0); end
         2'd1: for (int y = 0; y < H; y++) for (int x = W-1; x >= 0; x--) begin qa.push_back(y*W + x); qf.push_back(x == W-1); end
         2'd2: for (int x = 0; x < W; x++) for (int y = 0; y < H; y++) begin qa.push_back(y*W + x); qf.push_back(y == 0); end
         default: for (int x = 0; x < W; x++) for (int y = H-1; y >= 0; y--) begin qa.push_back(y*W + x); qf.push_back(y == H-1); end
      endcase
`ifdef LINE_GAP_EN
      gaps = ((m < 2) ? H : W) - 1;
`else
      gaps = 0;
`endif
      idx = 0; nstall = 0; first_v = -1; last_acc = -1; bubbles = 0; held5 = 0; stall_cnt = 0;
      seen_done = 0; p_stall = 0; stalled_once = 0; p_out = 0; p_v = 0; p_ls = 0;
      bus.stall = 1'b0;
      if (!prestarted) begin
         @(posedge clk); #1; bus.start = 1'b1; bus.mode = m;
         @(posedge clk); #1; bus.start = 1'b0;
      end
      bus.mode = 2'($urandom);
      cyc = 1;
      while (!seen_done && cyc < 200) begin
         @(negedge clk);
         if (stall_kind == 1 && !stalled_once && bus.pix_valid && bus.pix_out == 8'd5) begin
            bus.stall = 1'b1; stall_cnt = 2; stalled_once = 1;
         end
         #1;
         if (cyc == 1) begin
            check("busy_rise", bus.busy, 1);
            check("first_rd_en", bus.mem_rd_en, 1);
            check("first_addr", bus.mem_addr, qa[0]);
         end
         if (p_stall) begin
            check("hold_pix", bus.pix_out, p_out);
            check("hold_valid", bus.pix_valid, p_v);
            check("hold_ls", bus.line_start, p_ls);
         end
         if (bus.stall && !bus.done) check("stall_rd_en", bus.mem_rd_en, 0);
         if (!bus.pix_valid) check("ls_without_valid", bus.line_start, 0);
         if (bus.pix_valid) begin
            if (first_v < 0) first_v = cyc;
            if (bus.pix_out == 8'd5) held5++;
         end
         if (bus.pix_valid && !bus.stall) begin
            if (idx < NPIX) begin
               check("pix", bus.pix_out, mem[qa[idx]]);
               check("line_start", bus.line_start, qf[idx]);
            end else begin
               check("pix_count_over", idx + 1, NPIX);
            end
            idx++;
            last_acc = cyc;
         end else if (!bus.pix_valid && !bus.stall && first_v >= 0 && idx < NPIX) begin
            bubbles++;
         end
         if (bus.done) begin
            seen_done = 1;
            check("done_after_last", cyc, last_acc + 1);
            check("done_busy_low", bus.busy, 0);
            check("pix_count", idx, NPIX);
            check("done_cycle", cyc, 3 + NPIX + gaps + nstall);
            check("bubbles", bubbles, gaps);
            if (stall_kind == 0) check("first_valid_cycle", first_v, 3);
            if (stall_kind == 1) check("pix5_held", held5, 3);
            if (start_at_done) begin bus.start = 1'b1; bus.mode = 2'd2; end
         end else begin
            check("busy_mid", bus.busy, 1);
            if (bus.stall) nstall++;
         end
         p_out = bus.pix_out; p_v = bus.pix_valid; p_ls = bus.line_start; p_stall = bus.stall;
         if (!seen_done) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = (cyc == 5);
            if (stall_kind == 2) bus.stall = ($urandom_range(0, 3) == 0);
            else if (stall_cnt > 0) begin stall_cnt--; bus.stall = (stall_cnt > 0); end
         end
      end
      check("done_seen", seen_done, 1);
      bus.stall = 1'b0;
   endtask

   initial begin
      bit found;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.mode = 2'd0;
      bus.stall = 1'b0;
      for (int a = 0; a < 16; a++) mem[a] = 8'(a);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      run_frame(2'd0, 0, 0, 0, 0);
      run_frame(2'd1, 0, 0, 0, 0);
      run_frame(2'd2, 0, 0, 0, 0);
      run_frame(2'd3, 0, 0, 0, 1);
      @(posedge clk); #1;
      check("start_at_done_ignored", bus.busy, 0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      run_frame(2'd2, 0, 0, 1, 0);

      run_frame(2'd0, 1, 0, 0, 0);

      // Abort a frame by reset after pixel 6, then a clean frame must follow.
      @(posedge clk); #1; bus.start = 1'b1; bus.mode = 2'd0;
      @(posedge clk); #1; bus.start = 1'b0;
      found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (bus.pix_valid && bus.pix_out == 8'd6) found = 1;
      end
      check("rst_find_pix6", found, 1);
      reset = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_no_done", bus.done, 0);
         check("rst_no_busy", bus.busy, 0);
      end
      @(negedge clk);
      reset = 1'b0;
      run_frame(2'd0, 0, 0, 0, 0);

      for (int k = 0; k < 6; k++) run_frame(2'($urandom), 2, 1, 0, 0);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
